// File: rtl/mux_pkg.sv
// ============================================================================
// mux_pkg -- shared defaults and mode encodings for the arb_mux slice.
// Rev 1.0
// ============================================================================
`default_nettype none

package mux_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_N_IN  = 4;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick -- rotating-priority search: first set req bit at ptr, ptr+1, ...
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] index
);

   localparam logic [SEL_W:0] C_N = (SEL_W+1)'(N);

   logic [SEL_W:0] w_pos;

   // ptr is always < N, so one conditional subtract wraps the candidate.
   always_comb begin
      found = 1'b0;
      index = '0;
      w_pos = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = {1'b0, ptr} + (SEL_W+1)'(k);
         if (w_pos >= C_N) begin
            w_pos = w_pos - C_N;
         end
         if (!found && req[w_pos[SEL_W-1:0]]) begin
            found = 1'b1;
            index = w_pos[SEL_W-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/arb_mux.sv
// ============================================================================
// arb_mux -- N-way arbitrating mux (fixed/round-robin) into a 1-entry register.
// Rev 1.0
// ============================================================================
`default_nettype none

module arb_mux
   import mux_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int N_IN  = DEF_N_IN,
   localparam int SEL_W = $clog2(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [N_IN-1:0]       in_valid,
   output logic [N_IN-1:0]       in_ready,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      out_src
);

   localparam logic [SEL_W:0]   C_N    = (SEL_W+1)'(N_IN);
   localparam logic [SEL_W-1:0] C_LAST = SEL_W'(N_IN - 1);

   logic [WIDTH-1:0] w_chan [N_IN];
   logic             w_load_en;
   logic             w_fix_found;
   logic             w_rr_found;
   logic [SEL_W-1:0] w_rr_idx;
   logic             w_found;
   logic [SEL_W-1:0] w_idx;

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [SEL_W-1:0] r_src;
   logic [SEL_W-1:0] r_ptr;

   for (genvar i = 0; i < N_IN; i++) begin : g_unpack
      assign w_chan[i] = in_data[i*WIDTH +: WIDTH];
   end

   rr_pick #(
      .N     (N_IN),
      .SEL_W (SEL_W)
   ) u_rr_pick (
      .req   (in_valid),
      .ptr   (r_ptr),
      .found (w_rr_found),
      .index (w_rr_idx)
   );

   assign w_load_en   = !r_valid || out_ready;
   assign w_fix_found = ({1'b0, sel} < C_N) && in_valid[sel];

   always_comb begin
      w_found = w_fix_found;
      w_idx   = sel;
      if (mode == MODE_RR) begin
         w_found = w_rr_found;
         w_idx   = w_rr_idx;
      end
   end

   // Strobes are masked during reset so no input transfer can count then.
   always_comb begin
      in_ready = '0;
      if (!rst && w_load_en && w_found) begin
         in_ready[w_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_src   <= '0;
         r_ptr   <= '0;
      end else if (w_load_en) begin
         r_valid <= w_found;
         if (w_found) begin
            r_data <= w_chan[w_idx];
            r_src  <= w_idx;
         end
         if (w_found && mode == MODE_RR) begin
            r_ptr <= (w_idx == C_LAST) ? '0 : w_idx + 1'b1;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_src   = r_src;

endmodule

`default_nettype wire

// File: tb/tb_arb_mux.sv
// ============================================================================
// tb_arb_mux -- scoreboard bench for arb_mux (WIDTH=16, N_IN=4).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_arb_mux;

   localparam int W = 16;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N*W-1:0] in_data;
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_ready;
   logic          mode;
   logic [1:0]    sel;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_src;

   arb_mux #(.WIDTH(W), .N_IN(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_src   (out_src)
   );

   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_err = 0;
   logic [W-1:0]  dat [N];
   logic [W+1:0]  sb_q [$];     // {src, data}
   logic          m_valid;
   int            m_ptr;
   logic [W-1:0]  held;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic pack();
      for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
   endtask

   function automatic void model_grant(output logic f, output int g);
      f = 1'b0;
      g = 0;
      if (mode == 1'b0) begin
         if (int'(sel) < N && in_valid[sel]) begin
            f = 1'b1;
            g = int'(sel);
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!f && in_valid[j]) begin
               f = 1'b1;
               g = j;
            end
         end
      end
   endfunction

   // Called just after a falling edge with inputs already driven.
   task automatic step();
      logic         f;
      int           g;
      logic         ld;
      logic [N-1:0] er;
      logic [W+1:0] e;
      pack();
      #1;
      ld = !m_valid || out_ready;
      model_grant(f, g);
      er = (ld && f) ? (N'(1) << g) : '0;
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(1), 32'(0));
         end else begin
            e = sb_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e[W-1:0]));
            chk("out_src", 32'(out_src), 32'(e[W+1:W]));
         end
      end
      if (ld) begin
         m_valid = f;
         if (f) begin
            sb_q.push_back({2'(g), dat[g]});
            if (mode) m_ptr = (g + 1) % N;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_valid = 1'b0;
      m_ptr   = 0;
   endtask

   initial begin
      logic [1:0] seq [6];
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      // Reset held three cycles with every channel requesting.
      rst = 1'b1; mode = 1'b0; sel = 2'd0; out_ready = 1'b1; in_valid = 4'b1111;
      for (int i = 0; i < N; i++) dat[i] = W'(16'h1000 + i);
      pack();
      model_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_valid", 32'(out_valid), 32'd0);
         chk("rst_data", 32'(out_data), 32'd0);
         chk("rst_ready", 32'(in_ready), 32'd0);
      end
      rst = 1'b0;

      // Fixed select of channel 2.
      mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; dat[2] = 16'hBEEF;
      step();
      chk("fix_data", 32'(out_data), 32'h0000BEEF);
      chk("fix_src", 32'(out_src), 32'd2);
      // Fixed select of a non-requesting channel grants nothing.
      sel = 2'd1; in_valid = 4'b1101;
      step();
      chk("fix_nogrant", 32'(out_valid), 32'd0);
      chk("fix_hold_data", 32'(out_data), 32'h0000BEEF);

      // Round-robin with everyone requesting.
      mode = 1'b1; in_valid = 4'b1111;
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++) dat[i] = W'(16'h2000 + c * 16 + i);
         step();
         chk("rr_seq", 32'(out_src), 32'(seq[c]));
      end

      // Wrap and skip: move ptr to 3, then requesters 0 and 2 only.
      in_valid = 4'b0100;
      step();
      in_valid = 4'b0101;
      step();
      chk("wrap_src0", 32'(out_src), 32'd0);
      step();
      chk("wrap_src2", 32'(out_src), 32'd2);
      in_valid = 4'b0000;
      step();

      // Backpressure: hold word from channel 3 while inputs churn.
      in_valid = 4'b1111;
      step();
      held = out_data;
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < N; i++) dat[i] = W'($urandom);
         step();
         chk("bp_data", 32'(out_data), 32'(held));
         chk("bp_src", 32'(out_src), 32'd3);
      end
      out_ready = 1'b1;
      step();
      chk("bp_resume_src", 32'(out_src), 32'd0);

      // Asynchronous reset pulse while a word is held.
      in_valid = 4'b0010;
      step();
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_data", 32'(out_data), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      in_valid = 4'b1111;
      step();
      chk("arst_restart", 32'(out_src), 32'd0);

      // Random mix of modes, selects, requests and backpressure.
      for (int c = 0; c < 60; c++) begin
         mode      = 1'($urandom);
         sel       = 2'($urandom);
         in_valid  = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) dat[i] = W'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
